pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle with master/slave views
interface pipeline_hazard_ctrl_if;
    logic        start_i;
    logic        mem_stall_i;
    logic [4:0]  ID_rs1_i;
    logic [4:0]  ID_rs2_i;
    logic        ID_EX_MemRead_i;
    logic [4:0]  ID_EX_rd_i;
    logic        branch_taken_i;
    logic        PCWrite_o;
    logic        IF_IDWrite_o;
    logic        IF_IDflush_o;
    logic        ID_EXnop_o;
    logic        freeze_o;
    logic        error_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    modport master (
        output start_i, mem_stall_i, ID_rs1_i, ID_rs2_i,
               ID_EX_MemRead_i, ID_EX_rd_i, branch_taken_i,
        input  PCWrite_o, IF_IDWrite_o, IF_IDflush_o, ID_EXnop_o,
               freeze_o, error_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, mem_stall_i, ID_rs1_i, ID_rs2_i,
               ID_EX_MemRead_i, ID_EX_rd_i, branch_taken_i,
        output PCWrite_o, IF_IDWrite_o, IF_IDflush_o, ID_EXnop_o,
               freeze_o, error_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - in-order pipeline hazard controller (stall, bubble, flush, timeout)
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_STALL, S_ERROR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt, tmo_nxt;
    logic [8:0]  tmo_inc;
    logic [15:0] stall_cnt, flush_cnt;
    logic        load_use;
    logic        pc_write, ifid_write, ifid_flush, idex_nop, freeze, stall_evt;

    assign load_use = hz.ID_EX_MemRead_i && (hz.ID_EX_rd_i != 5'd0) &&
                      ((hz.ID_EX_rd_i == hz.ID_rs1_i) || (hz.ID_EX_rd_i == hz.ID_rs2_i));

    assign tmo_inc = {1'b0, tmo_cnt} + 9'd1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // RUN and MEM_STALL share one output decode so the first cycle after a
    // memory stall clears already behaves exactly like RUN.
    always_comb begin
        state_nxt  = state;
        tmo_nxt    = 8'd0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        freeze     = 1'b0;
        stall_evt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hz.start_i) state_nxt = S_RUN;
            end
            S_RUN, S_MEM_STALL: begin
                if (!hz.start_i) begin
                    state_nxt = S_IDLE;
                end else if (hz.mem_stall_i) begin
                    freeze    = 1'b1;
                    stall_evt = 1'b1;
                    tmo_nxt   = tmo_inc[7:0];
                    state_nxt = (tmo_inc >= 9'(TIMEOUT)) ? S_ERROR : S_MEM_STALL;
                end else if (load_use) begin
                    idex_nop  = 1'b1;
                    stall_evt = 1'b1;
                    state_nxt = S_RUN;
                end else if (hz.branch_taken_i) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = S_RUN;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            S_ERROR: begin
                freeze  = 1'b1;
                tmo_nxt = tmo_cnt;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (ifid_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign hz.PCWrite_o    = pc_write;
    assign hz.IF_IDWrite_o = ifid_write;
    assign hz.IF_IDflush_o = ifid_flush;
    assign hz.ID_EXnop_o   = idex_nop;
    assign hz.freeze_o     = freeze;
    assign hz.error_o      = (state == S_ERROR);
    assign hz.stall_cnt_o  = stall_cnt;
    assign hz.flush_cnt_o  = flush_cnt;
endmodule
